// File: rtl/core_memory_arbiter_if.sv
// Bus bundle between the core fetch/load-store ports, the arbiter and the memory port.
// slave = arbiter view, master = core/memory environment view.
interface core_memory_arbiter_if;
    logic        iINST_REQ;
    logic        oINST_LOCK;
    logic [31:0] iINST_ADDR;
    logic        oINST_VALID;
    logic        iINST_BUSY;
    logic        iDATA_REQ;
    logic        oDATA_LOCK;
    logic [1:0]  iDATA_ORDER;
    logic [3:0]  iDATA_MASK;
    logic        iDATA_RW;
    logic [31:0] iDATA_ADDR;
    logic [31:0] iDATA_DATA;
    logic        oDATA_VALID;
    logic [63:0] oRESP_DATA;
    logic        oMEM_REQ;
    logic        iMEM_LOCK;
    logic [1:0]  oMEM_ORDER;
    logic [3:0]  oMEM_MASK;
    logic        oMEM_RW;
    logic [31:0] oMEM_ADDR;
    logic [31:0] oMEM_DATA;
    logic        iMEM_VALID;
    logic        oMEM_BUSY;
    logic [63:0] iMEM_DATA;
    logic        oRESP_ERR;

    modport slave (
        input  iINST_REQ, iINST_ADDR, iINST_BUSY,
        input  iDATA_REQ, iDATA_ORDER, iDATA_MASK, iDATA_RW, iDATA_ADDR, iDATA_DATA,
        input  iMEM_LOCK, iMEM_VALID, iMEM_DATA,
        output oINST_LOCK, oINST_VALID, oDATA_LOCK, oDATA_VALID, oRESP_DATA,
        output oMEM_REQ, oMEM_ORDER, oMEM_MASK, oMEM_RW, oMEM_ADDR, oMEM_DATA,
        output oMEM_BUSY, oRESP_ERR
    );

    modport master (
        output iINST_REQ, iINST_ADDR, iINST_BUSY,
        output iDATA_REQ, iDATA_ORDER, iDATA_MASK, iDATA_RW, iDATA_ADDR, iDATA_DATA,
        output iMEM_LOCK, iMEM_VALID, iMEM_DATA,
        input  oINST_LOCK, oINST_VALID, oDATA_LOCK, oDATA_VALID, oRESP_DATA,
        input  oMEM_REQ, oMEM_ORDER, oMEM_MASK, oMEM_RW, oMEM_ADDR, oMEM_DATA,
        input  oMEM_BUSY, oRESP_ERR
    );
endinterface

// File: rtl/core_memory_arbiter.sv
// Fetch/data arbiter onto one memory port with an in-order read-owner ID FIFO.
// Define CORE_MEM_ARB_ROUND_ROBIN_EN for round-robin grant; default is data-over-fetch priority.
module core_memory_arbiter #(
    parameter int P_PEND_N = 2
) (
    input logic                  iCLOCK,
    input logic                  inRESET,
    core_memory_arbiter_if.slave bus
);
    localparam int   DEPTH   = 1 << P_PEND_N;
    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    logic [P_PEND_N-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [P_PEND_N:0]   count_q, count_d;
    logic [DEPTH-1:0]    id_q, id_d;
    logic                resp_err_q, resp_err_d;

    logic fifo_full, fifo_empty, inst_ok, data_ok, grant_inst, grant_data;
    logic accept, push, pop, head_id, inst_busy;
    logic [1:0]  mem_order;
    logic [3:0]  mem_mask;
    logic        mem_rw;
    logic [31:0] mem_addr, mem_data;

`ifdef CORE_MEM_ARB_ROUND_ROBIN_EN
    logic last_inst_q, last_inst_d;
`endif

    always_comb begin
        fifo_full  = (count_q == (P_PEND_N+1)'(DEPTH));
        fifo_empty = (count_q == '0);
        // Reads need a free ID slot; writes never occupy one.
        inst_ok = inRESET & bus.iINST_REQ & ~fifo_full;
        data_ok = inRESET & bus.iDATA_REQ & (~bus.iDATA_RW | ~fifo_full);
`ifdef CORE_MEM_ARB_ROUND_ROBIN_EN
        grant_data = data_ok & (~inst_ok | last_inst_q);
`else
        grant_data = data_ok;
`endif
        grant_inst = inst_ok & ~grant_data;
        accept     = (grant_inst | grant_data) & ~bus.iMEM_LOCK;
        push       = accept & (grant_inst | bus.iDATA_RW);
        head_id    = id_q[rd_ptr_q];
        inst_busy  = inRESET & ~fifo_empty & (head_id == ID_INST) & bus.iINST_BUSY;
        pop        = inRESET & bus.iMEM_VALID & ~fifo_empty & ~inst_busy;
    end

    always_comb begin
        mem_order = '0;
        mem_mask  = '0;
        mem_rw    = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
        if (grant_data) begin
            mem_order = bus.iDATA_ORDER;
            mem_mask  = bus.iDATA_MASK;
            mem_rw    = bus.iDATA_RW;
            mem_addr  = bus.iDATA_ADDR;
            mem_data  = bus.iDATA_DATA;
        end else if (grant_inst) begin
            mem_order = 2'b10;
            mem_mask  = 4'hF;
            mem_rw    = 1'b1;
            mem_addr  = bus.iINST_ADDR;
        end
    end

    assign bus.oMEM_REQ    = grant_inst | grant_data;
    assign bus.oMEM_ORDER  = mem_order;
    assign bus.oMEM_MASK   = mem_mask;
    assign bus.oMEM_RW     = mem_rw;
    assign bus.oMEM_ADDR   = mem_addr;
    assign bus.oMEM_DATA   = mem_data;
    assign bus.oINST_LOCK  = inRESET & bus.iINST_REQ & (~grant_inst | bus.iMEM_LOCK);
    assign bus.oDATA_LOCK  = inRESET & bus.iDATA_REQ & (~grant_data | bus.iMEM_LOCK);
    assign bus.oMEM_BUSY   = inst_busy;
    assign bus.oINST_VALID = pop & (head_id == ID_INST);
    assign bus.oDATA_VALID = pop & (head_id == ID_DATA);
    assign bus.oRESP_DATA  = bus.iMEM_DATA;
    assign bus.oRESP_ERR   = inRESET & resp_err_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        id_d       = id_q;
        resp_err_d = resp_err_q | (bus.iMEM_VALID & fifo_empty);
        if (push) begin
            id_d[wr_ptr_q] = grant_data;
            wr_ptr_d       = wr_ptr_q + P_PEND_N'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + P_PEND_N'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (P_PEND_N+1)'(1);
            2'b01:   count_d = count_q - (P_PEND_N+1)'(1);
            default: count_d = count_q;
        endcase
    end

`ifdef CORE_MEM_ARB_ROUND_ROBIN_EN
    assign last_inst_d = accept ? grant_inst : last_inst_q;

    // Reset to "fetch went last" so data wins the first contention.
    always_ff @(posedge iCLOCK) begin
        if (!inRESET) last_inst_q <= 1'b1;
        else          last_inst_q <= last_inst_d;
    end
`endif

    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            id_q       <= '0;
            resp_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            id_q       <= id_d;
            resp_err_q <= resp_err_d;
        end
    end
endmodule

// File: tb/tb_core_memory_arbiter.sv
// Self-checking bench for core_memory_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model (honours CORE_MEM_ARB_ROUND_ROBIN_EN).
module tb_core_memory_arbiter;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    core_memory_arbiter_if bus();

    core_memory_arbiter #(.P_PEND_N(2)) dut (
        .iCLOCK (clk),
        .inRESET(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        bus.iINST_REQ = 0; bus.iINST_ADDR = 0; bus.iINST_BUSY = 0;
        bus.iDATA_REQ = 0; bus.iDATA_ORDER = 0; bus.iDATA_MASK = 0; bus.iDATA_RW = 0;
        bus.iDATA_ADDR = 0; bus.iDATA_DATA = 0;
        bus.iMEM_LOCK = 0; bus.iMEM_VALID = 0; bus.iMEM_DATA = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        logic [8:0] act;
        @(negedge clk);
        rst_n = 0;
        bus.iINST_REQ = 1; bus.iDATA_REQ = 1; bus.iDATA_RW = 1; bus.iMEM_VALID = 1;
        #1;
        act = {bus.oMEM_REQ, bus.oINST_LOCK, bus.oDATA_LOCK, bus.oINST_VALID,
               bus.oDATA_VALID, bus.oMEM_BUSY, bus.oRESP_ERR, bus.oMEM_RW, |bus.oMEM_ADDR};
        total++;
        if (act !== 9'b0) begin
            bad++; $display("FAIL reset_during: outputs got %b need 000000000", act);
        end
        @(negedge clk);
        rst_n = 1;
        idle();
        #1;
        act = {bus.oMEM_REQ, bus.oINST_LOCK, bus.oDATA_LOCK, bus.oINST_VALID,
               bus.oDATA_VALID, bus.oMEM_BUSY, bus.oRESP_ERR, bus.oMEM_RW, |bus.oMEM_ADDR};
        total++;
        if (act !== 9'b0) begin
            bad++; $display("FAIL reset_idle: outputs got %b need 000000000", act);
        end
    endtask

    task automatic test_single_fetch();
        do_reset();
        bus.iINST_REQ = 1; bus.iINST_ADDR = 32'h100;
        #1;
        total++;
        if ({bus.oMEM_REQ, bus.oMEM_ADDR, bus.oMEM_RW, bus.oMEM_MASK, bus.oMEM_ORDER,
             bus.oMEM_DATA, bus.oINST_LOCK} !== {1'b1, 32'h100, 1'b1, 4'hF, 2'b10, 32'h0, 1'b0}) begin
            bad++; $display("FAIL fetch_fwd: req=%b addr=%h rw=%b mask=%h order=%b lock=%b need 1 100 1 f 10 0",
                            bus.oMEM_REQ, bus.oMEM_ADDR, bus.oMEM_RW, bus.oMEM_MASK, bus.oMEM_ORDER, bus.oINST_LOCK);
        end
        @(negedge clk);
        bus.iINST_REQ = 0;
        @(negedge clk);
        bus.iMEM_VALID = 1; bus.iMEM_DATA = 64'hDEAD_BEEF_0000_0001;
        #1;
        total++;
        if ({bus.oINST_VALID, bus.oDATA_VALID, bus.oRESP_DATA} !== {2'b10, 64'hDEAD_BEEF_0000_0001}) begin
            bad++; $display("FAIL fetch_ret: ivalid=%b dvalid=%b data=%h need 1 0 deadbeef00000001",
                            bus.oINST_VALID, bus.oDATA_VALID, bus.oRESP_DATA);
        end
        @(negedge clk);
        bus.iMEM_VALID = 0;
    endtask

    task automatic test_contention();
        bit ord[4];
        bit exp_d;
        do_reset();
        bus.iINST_REQ = 1; bus.iINST_ADDR = 32'h100;
        bus.iDATA_REQ = 1; bus.iDATA_RW = 1; bus.iDATA_ADDR = 32'h200;
        bus.iDATA_ORDER = 2'b10; bus.iDATA_MASK = 4'hF;
        for (int i = 0; i < 4; i++) begin
`ifdef CORE_MEM_ARB_ROUND_ROBIN_EN
            exp_d = (i % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            ord[i] = exp_d;
            #1;
            total++;
            if ({bus.oDATA_LOCK, bus.oINST_LOCK, bus.oMEM_ADDR} !== {!exp_d, exp_d, (exp_d ? 32'h200 : 32'h100)}) begin
                bad++; $display("FAIL contend_grant%0d: dlock=%b ilock=%b addr=%h need dlock=%b ilock=%b",
                                i, bus.oDATA_LOCK, bus.oINST_LOCK, bus.oMEM_ADDR, !exp_d, exp_d);
            end
            @(negedge clk);
        end
        bus.iINST_REQ = 0; bus.iDATA_REQ = 0;
        bus.iMEM_VALID = 1;
        for (int i = 0; i < 4; i++) begin
            bus.iMEM_DATA = 64'(i + 10);
            #1;
            total++;
            if ({bus.oDATA_VALID, bus.oINST_VALID} !== {ord[i], !ord[i]}) begin
                bad++; $display("FAIL contend_ret%0d: dvalid=%b ivalid=%b need %b %b",
                                i, bus.oDATA_VALID, bus.oINST_VALID, ord[i], !ord[i]);
            end
            @(negedge clk);
        end
        bus.iMEM_VALID = 0;
    endtask

    task automatic test_fifo_full();
        do_reset();
        bus.iDATA_REQ = 1; bus.iDATA_RW = 1; bus.iDATA_ADDR = 32'h40;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if ({bus.oMEM_REQ, bus.oDATA_LOCK} !== 2'b10) begin
                bad++; $display("FAIL full_fill%0d: req=%b lock=%b need 1 0", i, bus.oMEM_REQ, bus.oDATA_LOCK);
            end
            @(negedge clk);
        end
        #1;
        total++;
        if ({bus.oMEM_REQ, bus.oDATA_LOCK} !== 2'b01) begin
            bad++; $display("FAIL full_block_read: req=%b lock=%b need 0 1", bus.oMEM_REQ, bus.oDATA_LOCK);
        end
        bus.iDATA_REQ = 0; bus.iINST_REQ = 1;
        #1;
        total++;
        if ({bus.oMEM_REQ, bus.oINST_LOCK} !== 2'b01) begin
            bad++; $display("FAIL full_block_fetch: req=%b lock=%b need 0 1", bus.oMEM_REQ, bus.oINST_LOCK);
        end
        bus.iINST_REQ = 0; bus.iDATA_REQ = 1; bus.iDATA_RW = 0;
        #1;
        total++;
        if ({bus.oMEM_REQ, bus.oMEM_RW, bus.oDATA_LOCK} !== 3'b100) begin
            bad++; $display("FAIL full_write_pass: req=%b rw=%b lock=%b need 1 0 0",
                            bus.oMEM_REQ, bus.oMEM_RW, bus.oDATA_LOCK);
        end
        @(negedge clk);
        bus.iDATA_RW = 1; bus.iMEM_VALID = 1;
        #1;
        total++;
        if ({bus.oDATA_LOCK, bus.oMEM_REQ, bus.oDATA_VALID} !== 3'b101) begin
            bad++; $display("FAIL full_pop_push: lock=%b req=%b dvalid=%b need 1 0 1",
                            bus.oDATA_LOCK, bus.oMEM_REQ, bus.oDATA_VALID);
        end
        @(negedge clk);
        bus.iMEM_VALID = 0;
        #1;
        total++;
        if ({bus.oDATA_LOCK, bus.oMEM_REQ} !== 2'b01) begin
            bad++; $display("FAIL full_next_accept: lock=%b req=%b need 0 1", bus.oDATA_LOCK, bus.oMEM_REQ);
        end
        @(negedge clk);
        bus.iDATA_REQ = 0; bus.iMEM_VALID = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (bus.oDATA_VALID !== 1'b1) begin
                bad++; $display("FAIL full_drain%0d: dvalid=%b need 1", i, bus.oDATA_VALID);
            end
            @(negedge clk);
        end
        bus.iMEM_VALID = 0;
        #1;
        total++;
        if (bus.oRESP_ERR !== 1'b0) begin
            bad++; $display("FAIL full_drain_count: err=%b need 0", bus.oRESP_ERR);
        end
    endtask

    task automatic test_inst_busy();
        do_reset();
        bus.iINST_REQ = 1; bus.iINST_ADDR = 32'h300;
        @(negedge clk);
        bus.iINST_REQ = 0; bus.iMEM_VALID = 1; bus.iINST_BUSY = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({bus.oMEM_BUSY, bus.oINST_VALID} !== 2'b10) begin
                bad++; $display("FAIL busy_hold%0d: busy=%b ivalid=%b need 1 0", i, bus.oMEM_BUSY, bus.oINST_VALID);
            end
            @(negedge clk);
        end
        bus.iINST_BUSY = 0;
        #1;
        total++;
        if ({bus.oMEM_BUSY, bus.oINST_VALID} !== 2'b01) begin
            bad++; $display("FAIL busy_release: busy=%b ivalid=%b need 0 1", bus.oMEM_BUSY, bus.oINST_VALID);
        end
        @(negedge clk);
        #1;
        total++;
        if ({bus.oINST_VALID, bus.oRESP_ERR} !== 2'b00) begin
            bad++; $display("FAIL busy_popped: ivalid=%b err=%b need 0 0", bus.oINST_VALID, bus.oRESP_ERR);
        end
        @(negedge clk);
        bus.iMEM_VALID = 0;
        #1;
        total++;
        if (bus.oRESP_ERR !== 1'b1) begin
            bad++; $display("FAIL busy_err_set: err=%b need 1", bus.oRESP_ERR);
        end
    endtask

    task automatic test_err_and_reset();
        logic [8:0] act;
        do_reset();
        bus.iMEM_VALID = 1;
        #1;
        total++;
        if ({bus.oINST_VALID, bus.oDATA_VALID} !== 2'b00) begin
            bad++; $display("FAIL err_no_valid: ivalid=%b dvalid=%b need 0 0", bus.oINST_VALID, bus.oDATA_VALID);
        end
        @(negedge clk);
        bus.iMEM_VALID = 0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (bus.oRESP_ERR !== 1'b1) begin
            bad++; $display("FAIL err_sticky: err=%b need 1", bus.oRESP_ERR);
        end
        @(negedge clk);
        bus.iINST_REQ = 1; bus.iINST_ADDR = 32'h500;
        @(negedge clk);
        bus.iINST_REQ = 0; bus.iDATA_REQ = 1; bus.iDATA_RW = 1; bus.iDATA_ADDR = 32'h600;
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        idle();
        #1;
        act = {bus.oMEM_REQ, bus.oINST_LOCK, bus.oDATA_LOCK, bus.oINST_VALID,
               bus.oDATA_VALID, bus.oMEM_BUSY, bus.oRESP_ERR, bus.oMEM_RW, |bus.oMEM_ADDR};
        total++;
        if (act !== 9'b0) begin
            bad++; $display("FAIL midreset_outputs: got %b need 000000000", act);
        end
        bus.iMEM_VALID = 1;
        #1;
        total++;
        if ({bus.oINST_VALID, bus.oDATA_VALID} !== 2'b00) begin
            bad++; $display("FAIL midreset_count: ivalid=%b dvalid=%b need 0 0 (fifo empty)",
                            bus.oINST_VALID, bus.oDATA_VALID);
        end
        @(negedge clk);
        bus.iMEM_VALID = 0;
    endtask

    task automatic test_random();
        bit idq[$];
        bit err_m, last_inst, full, empty, ic, dc, win_d, win_i, head;
        logic [6:0]  exp_ctl, act_ctl;
        logic [70:0] exp_fwd, act_fwd;
        int nfail = 0;
        do_reset();
        err_m = 0; last_inst = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.iINST_REQ   = 1'($urandom_range(0, 1));
            bus.iINST_ADDR  = $urandom;
            bus.iINST_BUSY  = ($urandom_range(0, 3) == 0);
            bus.iDATA_REQ   = 1'($urandom_range(0, 1));
            bus.iDATA_RW    = 1'($urandom_range(0, 1));
            bus.iDATA_ORDER = 2'($urandom_range(0, 2));
            bus.iDATA_MASK  = 4'($urandom);
            bus.iDATA_ADDR  = $urandom;
            bus.iDATA_DATA  = $urandom;
            bus.iMEM_LOCK   = ($urandom_range(0, 3) == 0);
            bus.iMEM_VALID  = (idq.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 200) == 0);
            bus.iMEM_DATA   = {$urandom, $urandom};
            #1;
            full  = (idq.size() == DEPTH);
            empty = (idq.size() == 0);
            ic = bus.iINST_REQ && !full;
            dc = bus.iDATA_REQ && (!bus.iDATA_RW || !full);
`ifdef CORE_MEM_ARB_ROUND_ROBIN_EN
            win_d = (ic && dc) ? last_inst : dc;
`else
            win_d = dc;
`endif
            win_i = ic && !win_d;
            head  = empty ? 1'b0 : idq[0];
            exp_ctl = {win_i || win_d,
                       bus.iINST_REQ && !(win_i && !bus.iMEM_LOCK),
                       bus.iDATA_REQ && !(win_d && !bus.iMEM_LOCK),
                       bus.iMEM_VALID && !empty && !head && !bus.iINST_BUSY,
                       bus.iMEM_VALID && !empty && head,
                       !empty && !head && bus.iINST_BUSY,
                       err_m};
            if (win_d)      exp_fwd = {bus.iDATA_ORDER, bus.iDATA_MASK, bus.iDATA_RW, bus.iDATA_ADDR, bus.iDATA_DATA};
            else if (win_i) exp_fwd = {2'b10, 4'hF, 1'b1, bus.iINST_ADDR, 32'h0};
            else            exp_fwd = '0;
            act_ctl = {bus.oMEM_REQ, bus.oINST_LOCK, bus.oDATA_LOCK, bus.oINST_VALID,
                       bus.oDATA_VALID, bus.oMEM_BUSY, bus.oRESP_ERR};
            act_fwd = {bus.oMEM_ORDER, bus.oMEM_MASK, bus.oMEM_RW, bus.oMEM_ADDR, bus.oMEM_DATA};
            total++;
            if (act_ctl !== exp_ctl) begin
                bad++; nfail++;
                if (nfail < 10) $display("FAIL rand_ctl cyc%0d: got %b need %b (req ilock dlock iv dv busy err)",
                                         cyc, act_ctl, exp_ctl);
            end
            total++;
            if (act_fwd !== exp_fwd) begin
                bad++; nfail++;
                if (nfail < 10) $display("FAIL rand_fwd cyc%0d: got %h need %h", cyc, act_fwd, exp_fwd);
            end
            total++;
            if (bus.oRESP_DATA !== bus.iMEM_DATA) begin
                bad++; nfail++;
                if (nfail < 10) $display("FAIL rand_data cyc%0d: got %h need %h", cyc, bus.oRESP_DATA, bus.iMEM_DATA);
            end
            if (bus.iMEM_VALID && !empty && !(!head && bus.iINST_BUSY)) void'(idq.pop_front());
            if ((win_i || win_d) && !bus.iMEM_LOCK) begin
                if (win_i || bus.iDATA_RW) idq.push_back(win_d);
                last_inst = win_i;
            end
            if (bus.iMEM_VALID && empty) err_m = 1;
            @(negedge clk);
        end
        idle();
    endtask

    initial begin
        rst_n = 1;
        idle();
        test_reset();
        test_single_fetch();
        test_contention();
        test_fifo_full();
        test_inst_busy();
        test_err_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/core_memory_arbiter.md
Name:
core_memory_arbiter

Overview:
- Shares the single external memory port between the core's instruction-fetch requester and data-access requester.
- Arbitrates requests, forwards the winner downstream, and records the owner of every outstanding read in an in-order ID FIFO.
- Routes each returning iMEM_VALID beat back to the requester that owns it.
- Sits between the core pipeline fetch/load-store ports and the memory/cache interface.

Parameters:
- P_PEND_N, default 2: log2 of ID FIFO depth. Default gives 4 outstanding reads max.

Ports:
- iCLOCK  in  1  system clock
- inRESET  in  1  reset; synchronous to iCLOCK, active-low
- iINST_REQ  in  1  fetch request (always a read, 64-bit return)
- oINST_LOCK  out  1  fetch request not accepted this cycle
- iINST_ADDR  in  32  fetch address
- oINST_VALID  out  1  fetch return beat valid
- iINST_BUSY  in  1  fetch side cannot take a return beat
- iDATA_REQ  in  1  data request
- oDATA_LOCK  out  1  data request not accepted this cycle
- iDATA_ORDER  in  2  00 byte, 01 half, 10 word
- iDATA_MASK  in  4  byte mask
- iDATA_RW  in  1  0=write 1=read
- iDATA_ADDR  in  32  data address
- iDATA_DATA  in  32  write data
- oDATA_VALID  out  1  data read return beat valid
- oRESP_DATA  out  64  return data, shared; qualified by oINST_VALID or oDATA_VALID
- oMEM_REQ  out  1  downstream request
- iMEM_LOCK  in  1  downstream not accepting
- oMEM_ORDER  out  2  forwarded order (10 for fetch)
- oMEM_MASK  out  4  forwarded mask (4'hF for fetch)
- oMEM_RW  out  1  forwarded rw (1 for fetch)
- oMEM_ADDR  out  32  forwarded address
- oMEM_DATA  out  32  forwarded write data (0 for fetch)
- iMEM_VALID  in  1  downstream return beat
- oMEM_BUSY  out  1  backpressure to downstream returns
- iMEM_DATA  in  64  downstream return data
- oRESP_ERR  out  1  sticky: return beat arrived with ID FIFO empty

Behaviour:
- Request transfer rule (both sides): a transfer occurs on the cycle REQ=1 and LOCK=0. Request paths are combinational; zero added latency.
- Blocked condition: fifo_full = (count == 2**P_PEND_N). A read needs a FIFO slot.
  - Read request while fifo_full: oMEM_REQ=0 and requester LOCK=1.
  - Data write never enqueues and is not blocked by fifo_full.
- Grant:
  - Only one valid requester: it wins.
  - Both valid: priority policy (see Optional Feature).
  - Loser's LOCK=1. Winner's LOCK = iMEM_LOCK.
- Enqueue on a downstream read transfer: ID 0=inst, 1=data pushed at write pointer.
- Pointers and count:
  - Pointers wrap modulo depth.
  - count is P_PEND_N+1 bits.
  - Simultaneous push and pop: count unchanged.
  - Full gates the push regardless of a same-cycle pop.
- Return routing: on iMEM_VALID with FIFO non-empty, the head ID selects oINST_VALID or oDATA_VALID (combinational). oRESP_DATA = iMEM_DATA.
  - Pop when iMEM_VALID=1 and oMEM_BUSY=0.
  - oMEM_BUSY = (head ID==inst) & iINST_BUSY & non-empty. The data side never backpressures.
- iMEM_VALID with FIFO empty: no VALID out, no pop, oRESP_ERR set. It clears only on reset.
- Reset (inRESET=0 at a rising edge): count, pointers, RR pointer and oRESP_ERR cleared. Mid-operation reset discards all pending IDs; the downstream must be reset together.
- Outputs during reset/idle: oMEM_REQ=0, both VALIDs=0, oMEM_BUSY=0, LOCKs=0, oRESP_ERR=0, oMEM_* data/addr=0.

Optional Feature:
- Macro CORE_MEM_ARB_ROUND_ROBIN_EN.
  - Defined: 1-bit RR register. On contention, the side not granted last accepted transfer wins. The register updates only on an accepted transfer. Reset value favours data.
  - Undefined: fixed priority, data always beats instruction fetch.

Test Plan:
- Single fetch iINST_ADDR=32'h100, iMEM_LOCK=0 -> same-cycle oMEM_REQ=1, oMEM_ADDR=32'h100, oMEM_RW=1, oMEM_MASK=4'hF. Later iMEM_VALID with 64'hDEAD_BEEF_0000_0001 -> oINST_VALID=1 with that data, oDATA_VALID=0.
- Simultaneous fetch and data read, both held 4 cycles, unlimited returns:
  - Fixed mode: data granted first, inst LOCK=1.
  - RR mode: grants alternate D,I,D,I.
  - Returns route in the same D/I order.
- 4 reads with no returns (P_PEND_N=2) -> 5th read sees LOCK=1 and oMEM_REQ=0. A data write in the same state passes (oMEM_REQ=1, oMEM_RW=0). A return plus a new read in the same cycle -> read still locked, accepted next cycle.
- Inst-owned return with iINST_BUSY=1 for 3 cycles -> oMEM_BUSY=1, no pop, count stays. Busy drops -> oINST_VALID=1 and pop.
- iMEM_VALID with FIFO empty -> oRESP_ERR=1 persists. inRESET=0 for one edge mid-traffic with 2 pending -> count=0, oRESP_ERR=0, all outputs at reset values.
